// File: rtl/tri_bus_arbiter_rx.sv
// Round-robin controller and receiver for the shared tri-state bus.
// Grants one source at a time by driving its tri-state enable. The enable is
// held for a settle cycle and a sample cycle. The resolved bus value is then
// captured and tagged with the source ID. The bus is left fully released for
// DEAD_CYCLES cycles after every grant, so two buffers never drive at once.
//
// Handshake: a source holds req[i] high until it sees a done[i] pulse, and it
// drops req[i] on the following cycle. Dropping req[i] while its enable is in
// the settle cycle aborts the grant, with no done and no rx_valid. rx_valid is
// a one-cycle pulse qualifying rx_data/rx_src. There is no back-pressure on the
// receive side.
module tri_bus_arbiter_rx #(
    parameter int N_SRC       = 4,
    parameter int WIDTH       = 8,
    parameter int DEAD_CYCLES = 1,
    localparam int SRC_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    input  logic [WIDTH-1:0] bus_in,
    output logic [N_SRC-1:0] en,
    output logic [N_SRC-1:0] done,
    output logic [WIDTH-1:0] rx_data,
    output logic [SRC_W-1:0] rx_src,
    output logic             rx_valid,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        TURN   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [SRC_W-1:0] k_q, k_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic [N_SRC-1:0] en_q, en_d;
    logic [N_SRC-1:0] done_q, done_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [SRC_W-1:0] rx_src_q, rx_src_d;
    logic             rx_valid_q, rx_valid_d;
    logic             busy_q, busy_d;

    logic             sel_found;
    logic [SRC_W-1:0] sel_idx;
    logic [SRC_W-1:0] cand;

    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] i);
        if (int'(i) == N_SRC - 1) return '0;
        return i + 1'b1;
    endfunction

    function automatic logic [N_SRC-1:0] onehot(input logic [SRC_W-1:0] i);
        logic [N_SRC-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

    // Round-robin pick: first requesting source at or above ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cand = SRC_W'((int'(ptr_q) + i) % N_SRC);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic. The enable is computed for the
    // state being entered, so en is glitch-free and comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        k_d        = k_q;
        dead_d     = dead_q;
        en_d       = '0;
        done_d     = '0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        rx_src_d   = rx_src_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    k_d     = sel_idx;
                    en_d    = onehot(sel_idx);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (!req[k_q]) begin
                    // Source withdrew: release the bus and move the pointer past it.
                    ptr_d   = next_idx(k_q);
                    dead_d  = DEAD_LOAD;
                    state_d = TURN;
                end else begin
                    en_d    = onehot(k_q);
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                rx_data_d  = bus_in;
                rx_src_d   = k_q;
                rx_valid_d = 1'b1;
                done_d     = onehot(k_q);
                ptr_d      = next_idx(k_q);
                dead_d     = DEAD_LOAD;
                state_d    = TURN;
            end
            TURN: begin
                if (dead_q == '0) state_d = IDLE;
                else              dead_d  = dead_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset releases the bus without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            k_q        <= '0;
            dead_q     <= '0;
            en_q       <= '0;
            done_q     <= '0;
            rx_data_q  <= '0;
            rx_src_q   <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            k_q        <= k_d;
            dead_q     <= dead_d;
            en_q       <= en_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            rx_src_q   <= rx_src_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign en        = en_q;
    assign done      = done_q;
    assign rx_data   = rx_data_q;
    assign rx_src    = rx_src_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tri_bus_arbiter_rx.sv
// Directed bench for tri_bus_arbiter_rx: cycle table on a DEAD_CYCLES=1
// instance, then round-robin, long-turnaround and async-reset sequences.
module tb_tri_bus_arbiter_rx;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [7:0] bus_a, bus_b;
    logic [3:0] en_a, en_b, done_a, done_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic [1:0] rx_src_a, rx_src_b;
    logic       rx_valid_a, rx_valid_b, busy_a, busy_b;
    logic [1:0] st_a, st_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [1:0] exp_src_q[$];

    tri_bus_arbiter_rx #(.N_SRC(4), .WIDTH(8), .DEAD_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .bus_in(bus_a),
        .en(en_a), .done(done_a), .rx_data(rx_data_a), .rx_src(rx_src_a),
        .rx_valid(rx_valid_a), .busy(busy_a), .dbg_state(st_a)
    );

    tri_bus_arbiter_rx #(.N_SRC(4), .WIDTH(8), .DEAD_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .bus_in(bus_b),
        .en(en_b), .done(done_b), .rx_data(rx_data_b), .rx_src(rx_src_b),
        .rx_valid(rx_valid_b), .busy(busy_b), .dbg_state(st_b)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
        return 2'd0;
    endfunction

    // Value a source puts on the bus while it is enabled.
    function automatic logic [7:0] src_val(input logic [3:0] oh);
        if (oh == 4'b0) return 8'h00;
        return 8'hC0 | {6'b0, idx_of(oh)};
    endfunction

    typedef struct {
        logic [3:0] req;
        logic [7:0] bus;
        logic [3:0] en;
        logic [3:0] done;
        logic       rxv;
        logic [7:0] data;
        logic [1:0] src;
        logic       busy;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    int         grant_cyc[8];
    logic [1:0] grant_idx[8];
    int         ngrant, nrx, turn_cnt;
    logic [3:0] prev_en;
    logic [7:0] exp_d;
    logic [1:0] exp_s;

    initial begin
        // req, bus, en, done, rxv, data, src, busy (outputs after the edge)
        // Single request from source 1.
        vecs[0]  = '{4'b0010, 8'hA5, 4'b0010, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1};
        vecs[1]  = '{4'b0010, 8'hA5, 4'b0010, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1};
        vecs[2]  = '{4'b0010, 8'hA5, 4'b0000, 4'b0010, 1'b1, 8'hA5, 2'd1, 1'b1};
        vecs[3]  = '{4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'hA5, 2'd1, 1'b0};
        vecs[4]  = '{4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'hA5, 2'd1, 1'b0};
        // Serve source 2 so the pointer sits at 3.
        vecs[5]  = '{4'b0100, 8'h3C, 4'b0100, 4'b0000, 1'b0, 8'hA5, 2'd1, 1'b1};
        vecs[6]  = '{4'b0100, 8'h3C, 4'b0100, 4'b0000, 1'b0, 8'hA5, 2'd1, 1'b1};
        vecs[7]  = '{4'b0100, 8'h3C, 4'b0000, 4'b0100, 1'b1, 8'h3C, 2'd2, 1'b1};
        // Requests raised during the turnaround wait for IDLE; wrap 3 -> 0.
        vecs[8]  = '{4'b0011, 8'h11, 4'b0000, 4'b0000, 1'b0, 8'h3C, 2'd2, 1'b0};
        vecs[9]  = '{4'b0011, 8'h11, 4'b0001, 4'b0000, 1'b0, 8'h3C, 2'd2, 1'b1};
        vecs[10] = '{4'b0011, 8'h11, 4'b0001, 4'b0000, 1'b0, 8'h3C, 2'd2, 1'b1};
        vecs[11] = '{4'b0011, 8'h11, 4'b0000, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1};
        vecs[12] = '{4'b0010, 8'h22, 4'b0000, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b0};
        vecs[13] = '{4'b0010, 8'h22, 4'b0010, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b1};
        vecs[14] = '{4'b0010, 8'h22, 4'b0010, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b1};
        vecs[15] = '{4'b0010, 8'h22, 4'b0000, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1};
        vecs[16] = '{4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b0};
        // Pointer back at 2: req 0111 picks 2; it withdraws during DRIVE.
        vecs[17] = '{4'b0111, 8'h55, 4'b0100, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b1};
        vecs[18] = '{4'b0011, 8'h55, 4'b0000, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b1};
        vecs[19] = '{4'b0011, 8'h55, 4'b0000, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b0};
        // Search resumes at 3 after the abort.
        vecs[20] = '{4'b1001, 8'h99, 4'b1000, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b1};
        vecs[21] = '{4'b1001, 8'h99, 4'b1000, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b1};
        vecs[22] = '{4'b1001, 8'h99, 4'b0000, 4'b1000, 1'b1, 8'h99, 2'd3, 1'b1};
        vecs[23] = '{4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h99, 2'd3, 1'b0};
        vecs[24] = '{4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h99, 2'd3, 1'b0};

        // Reset state.
        rst_n = 1'b0;
        req_a = '0; req_b = '0; bus_a = '0; bus_b = '0;
        #3;
        check("rst_en_a", 32'(en_a), 32'h0);
        check("rst_busy_a", 32'(busy_a), 32'h0);
        check("rst_rxv_a", 32'(rx_valid_a), 32'h0);
        check("rst_en_b", 32'(en_b), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Cycle table on instance A.
        for (int v = 0; v < NV; v++) begin
            req_a = vecs[v].req;
            bus_a = vecs[v].bus;
            @(posedge clk); #1;
            check($sformatf("v%0d_en", v), 32'(en_a), 32'(vecs[v].en));
            check($sformatf("v%0d_done", v), 32'(done_a), 32'(vecs[v].done));
            check($sformatf("v%0d_rxv", v), 32'(rx_valid_a), 32'(vecs[v].rxv));
            check($sformatf("v%0d_data", v), 32'(rx_data_a), 32'(vecs[v].data));
            check($sformatf("v%0d_src", v), 32'(rx_src_a), 32'(vecs[v].src));
            check($sformatf("v%0d_busy", v), 32'(busy_a), 32'(vecs[v].busy));
        end

        // Round robin with all sources requesting; pointer starts at 0.
        exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC0};
        exp_src_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req_a = 4'b1111;
        prev_en = '0; ngrant = 0; nrx = 0;
        for (int cyc = 0; cyc < 60 && nrx < 5; cyc++) begin
            bus_a = src_val(en_a);
            @(posedge clk); #1;
            check("rr_onehot", 32'($countones(en_a) <= 1), 32'h1);
            if (en_a != 4'b0 && prev_en == 4'b0 && ngrant < 8) begin
                grant_cyc[ngrant] = cyc;
                grant_idx[ngrant] = idx_of(en_a);
                ngrant++;
            end
            prev_en = en_a;
            if (rx_valid_a) begin
                nrx++;
                if (exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    exp_s = exp_src_q.pop_front();
                    check("rr_data", 32'(rx_data_a), 32'(exp_d));
                    check("rr_src", 32'(rx_src_a), 32'(exp_s));
                    check("rr_done", 32'(done_a), 32'(4'b0001 << exp_s));
                end else begin
                    check("rr_extra_rx", 32'(rx_valid_a), 32'h0);
                end
            end
        end
        req_a = '0;
        check("rr_grant_count", 32'(ngrant), 32'd5);
        check("rr_rx_left", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 5 && i < ngrant; i++) begin
            check($sformatf("rr_order%0d", i), 32'(grant_idx[i]), 32'(i % 4));
            if (i > 0)
                check($sformatf("rr_spacing%0d", i), 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd4);
        end
        repeat (3) @(posedge clk);
        #1;

        // DEAD_CYCLES=3 on instance B with sources 0 and 2 held.
        req_b = 4'b0101;
        prev_en = '0; ngrant = 0; nrx = 0; turn_cnt = 0;
        for (int cyc = 0; cyc < 60 && nrx < 3; cyc++) begin
            bus_b = src_val(en_b);
            @(posedge clk); #1;
            check("dead_onehot", 32'($countones(en_b) <= 1), 32'h1);
            if (en_b == 4'b0 && busy_b) turn_cnt++;
            if (en_b != 4'b0 && prev_en == 4'b0 && ngrant < 8) begin
                if (ngrant > 0) check("dead_turn_len", 32'(turn_cnt), 32'd3);
                turn_cnt = 0;
                grant_cyc[ngrant] = cyc;
                grant_idx[ngrant] = idx_of(en_b);
                ngrant++;
            end
            prev_en = en_b;
            if (rx_valid_b) begin
                nrx++;
                check("dead_data", 32'(rx_data_b), 32'(src_val(4'b0001 << rx_src_b)));
            end
        end
        req_b = '0;
        check("dead_grant_count", 32'(ngrant), 32'd3);
        if (ngrant >= 3) begin
            check("dead_order0", 32'(grant_idx[0]), 32'd0);
            check("dead_order1", 32'(grant_idx[1]), 32'd2);
            check("dead_order2", 32'(grant_idx[2]), 32'd0);
            check("dead_spacing1", 32'(grant_cyc[1] - grant_cyc[0]), 32'd6);
            check("dead_spacing2", 32'(grant_cyc[2] - grant_cyc[1]), 32'd6);
        end
        repeat (6) @(posedge clk);
        #1;

        // Async reset mid-SAMPLE on instance A (pointer is 1, so 0100 picks 2).
        req_a = 4'b0100;
        bus_a = 8'hEE;
        @(posedge clk); #1;
        check("ar_drive_en", 32'(en_a), 32'h4);
        @(posedge clk); #1;
        check("ar_sample_en", 32'(en_a), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_en_now", 32'(en_a), 32'h0);
        check("ar_done_now", 32'(done_a), 32'h0);
        check("ar_rxv_now", 32'(rx_valid_a), 32'h0);
        check("ar_busy_now", 32'(busy_a), 32'h0);
        req_a = '0;
        @(posedge clk); #1;
        check("ar_rxv_held", 32'(rx_valid_a), 32'h0);
        check("ar_data_cleared", 32'(rx_data_a), 32'h0);
        rst_n = 1'b1;
        req_a = 4'b1000;
        bus_a = 8'h5A;
        @(posedge clk); #1;
        check("ar_e0_en", 32'(en_a), 32'h8);
        check("ar_e0_busy", 32'(busy_a), 32'h1);
        @(posedge clk); #1;
        check("ar_e1_en", 32'(en_a), 32'h8);
        check("ar_e1_rxv", 32'(rx_valid_a), 32'h0);
        @(posedge clk); #1;
        check("ar_e2_rxv", 32'(rx_valid_a), 32'h1);
        check("ar_e2_data", 32'(rx_data_a), 32'h5A);
        check("ar_e2_src", 32'(rx_src_a), 32'h3);
        check("ar_e2_done", 32'(done_a), 32'h8);
        check("ar_e2_en", 32'(en_a), 32'h0);
        req_a = '0;
        @(posedge clk); #1;
        check("ar_idle_busy", 32'(busy_a), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
